l1_dcache_wb: RTL and testbench



---
 rtl/l1_dcache_wb_if.sv | 26 ++
 rtl/l1_dcache_wb.sv | 130 +++++++++++++
 tb/tb_l1_dcache_wb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_wb_if.sv
// l1_dcache_wb_if: CPU-side request bundle and next-level line port of the L1 data cache
interface l1_dcache_wb_if;
    logic         dcache_req;
    logic [15:0]  dcache_addr;
    logic         dcache_wr_en;
    logic [15:0]  dcache_wr_sel;
    logic [127:0] dcache_wdata;
    logic         dcache_resp;
    logic [127:0] dcache_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  dcache_req, dcache_addr, dcache_wr_en, dcache_wr_sel, dcache_wdata, pmem_rdata, pmem_resp,
        output dcache_resp, dcache_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output dcache_req, dcache_addr, dcache_wr_en, dcache_wr_sel, dcache_wdata, pmem_rdata, pmem_resp,
        input  dcache_resp, dcache_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/l1_dcache_wb.sv
// l1_dcache_wb: direct-mapped write-back write-allocate L1 dcache; DCACHE_PERF_EN adds hit/miss counters
module l1_dcache_wb #(
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic clk,
    input  logic rst_n,
    l1_dcache_wb_if.slave bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0] perf_hits,
    output logic [15:0] perf_misses
`endif
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 12 - IW;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TW-1:0]       tag_q [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];
    logic                resp_q, resp_d, rd_q, rd_d, wr_q, wr_d;
    logic [127:0]        rdata_q, rdata_d, wdata_q, wdata_d;
    logic [15:0]         paddr_q, paddr_d;
`ifdef DCACHE_PERF_EN
    logic [15:0]         hits_q, hits_d, misses_q, misses_d;
`endif

    logic [IW-1:0] idx;
    logic [TW-1:0] rtag;
    logic hit, victim_dirty, start, miss, lk_wr, wb_done, fill_done, unused_ok;

    assign idx          = bus.dcache_addr[4+IW-1:4];
    assign rtag         = bus.dcache_addr[15:4+IW];
    assign hit          = valid_q[idx] && tag_q[idx] == rtag;
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign start        = state_q == IDLE && bus.dcache_req;
    assign miss         = state_q == LOOKUP && !hit;
    assign lk_wr        = state_q == LOOKUP && hit && bus.dcache_wr_en;
    assign wb_done      = state_q == WRITEBACK && bus.pmem_resp;
    assign fill_done    = state_q == FILL && bus.pmem_resp;
    assign unused_ok    = &{1'b0, bus.dcache_addr[3:0]};

    assign bus.dcache_resp  = resp_q;
    assign bus.dcache_rdata = rdata_q;
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_addr    = paddr_q;
    assign bus.pmem_wdata   = wdata_q;
`ifdef DCACHE_PERF_EN
    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif

    // next-state, registered outputs (resp is decided one edge early so it is high during LOOKUP) and line status
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        resp_d  = (start && hit) || fill_done;
        rdata_d = start ? data_q[idx] : fill_done ? bus.pmem_rdata : rdata_q;
        rd_d    = (miss && !victim_dirty) || wb_done || (state_q == FILL && !bus.pmem_resp);
        wr_d    = (miss && victim_dirty) || (state_q == WRITEBACK && !bus.pmem_resp);
        paddr_d = (miss && victim_dirty) ? {tag_q[idx], idx, 4'h0} :
                  (miss || wb_done) ? {rtag, idx, 4'h0} : paddr_q;
        wdata_d = miss ? data_q[idx] : wdata_q;
`ifdef DCACHE_PERF_EN
        hits_d   = (start && hit && hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;
        misses_d = (start && !hit && misses_q != 16'hFFFF) ? misses_q + 16'd1 : misses_q;
`endif
        case (state_q)
            IDLE:      state_d = bus.dcache_req ? LOOKUP : IDLE;
            LOOKUP:    state_d = hit ? IDLE : victim_dirty ? WRITEBACK : FILL;
            WRITEBACK: state_d = bus.pmem_resp ? FILL : WRITEBACK;
            default:   state_d = bus.pmem_resp ? LOOKUP : FILL;
        endcase
        if (lk_wr) dirty_d[idx] = 1'b1;
        if (wb_done) dirty_d[idx] = 1'b0;
        if (fill_done) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
    end

    // control state and outputs; reset drops everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            paddr_q  <= '0;
            wdata_q  <= '0;
`ifdef DCACHE_PERF_EN
            hits_q   <= '0;
            misses_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            paddr_q  <= paddr_d;
            wdata_q  <= wdata_d;
`ifdef DCACHE_PERF_EN
            hits_q   <= hits_d;
            misses_q <= misses_d;
`endif
        end
    end

    // tag/data storage: fill replaces the line, a write hit merges the selected bytes
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[idx] <= bus.pmem_rdata;
            tag_q[idx]  <= rtag;
        end else if (lk_wr) begin
            for (int i = 0; i < LINE_BYTES; i++)
                if (bus.dcache_wr_sel[i]) data_q[idx][8*i +: 8] <= bus.dcache_wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_l1_dcache_wb.sv
// tb_l1_dcache_wb: directed + random accesses against a set/line-level cache model and a backing-store map
module tb_l1_dcache_wb;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1_dcache_wb_if bus ();
`ifdef DCACHE_PERF_EN
    logic [15:0] perf_hits, perf_misses;
`endif

    l1_dcache_wb #(.NUM_SETS(NS), .LINE_BYTES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DCACHE_PERF_EN
        ,
        .perf_hits(perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    int n_assert = 0;
    int n_fail = 0;
    int n_hit = 0;
    int n_miss = 0;

    bit           m_valid [NS];
    bit           m_dirty [NS];
    logic [15:0]  m_line  [NS];
    logic [127:0] m_data  [NS];
    logic [127:0] mem [logic [15:0]];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] d, input logic [15:0] s);
        merge = o;
        for (int i = 0; i < 16; i++) if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        n_hit = 0;
        n_miss = 0;
    endtask

    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] sel, input logic [127:0] wd);
        int idx, rl, wl, cyc, exp_cyc;
        logic [15:0] la, vaddr;
        logic [127:0] vdata, fdata, exp_line;
        bit hit, dirtyv, got, saw_rd, saw_wr, both, stray;
        idx = int'((a >> 4) % NS);
        la = a & 16'hFFF0;
        hit = m_valid[idx] && m_line[idx] == la;
        dirtyv = !hit && m_valid[idx] && m_dirty[idx];
        vaddr = m_line[idx];
        vdata = m_data[idx];
        if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
        fdata = mem[la];
        exp_line = hit ? m_data[idx] : fdata;
        rl = $urandom_range(0, 3);
        wl = $urandom_range(0, 3);
        exp_cyc = hit ? 1 : dirtyv ? 4 + rl + wl : 3 + rl;
        if (dirtyv) mem[vaddr] = vdata;
        m_dirty[idx] = (hit && m_dirty[idx]) || w;
        m_valid[idx] = 1;
        m_line[idx] = la;
        m_data[idx] = w ? merge(exp_line, wd, sel) : exp_line;
        if (hit) n_hit++; else n_miss++;
        @(negedge clk);
        bus.dcache_req = 1'b1;
        bus.dcache_addr = a;
        bus.dcache_wr_en = w;
        bus.dcache_wr_sel = sel;
        bus.dcache_wdata = wd;
        cyc = 0;
        got = 0; saw_rd = 0; saw_wr = 0; both = 0; stray = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) both = 1;
            if (bus.dcache_resp) begin
                got = 1;
                bus.dcache_req = 1'b0;
            end else if (bus.pmem_write) begin
                if (!saw_wr) begin
                    check("wb_addr", 128'(bus.pmem_addr), 128'(vaddr));
                    check("wb_data", bus.pmem_wdata, vdata);
                end
                if (!dirtyv || saw_rd) stray = 1;
                saw_wr = 1;
                if (wl == 0) bus.pmem_resp = 1'b1; else wl--;
            end else if (bus.pmem_read) begin
                if (!saw_rd) check("fill_addr", 128'(bus.pmem_addr), 128'(la));
                if (hit || (dirtyv && !saw_wr)) stray = 1;
                saw_rd = 1;
                if (rl == 0) begin
                    bus.pmem_rdata = fdata;
                    bus.pmem_resp = 1'b1;
                end else rl--;
            end
        end
        bus.dcache_req = 1'b0;
        bus.pmem_resp = 1'b0;
        check("resp_seen", 128'(got), 128'(1));
        check("rdata", bus.dcache_rdata, exp_line);
        check("latency", 128'(cyc), 128'(exp_cyc));
        check("rd_wr_overlap", 128'(both), 128'(0));
        check("pmem_traffic", {126'b0, saw_wr, saw_rd}, {126'b0, dirtyv, !hit});
        check("pmem_order", 128'(stray), 128'(0));
        @(negedge clk);
        check("resp_one_pulse", 128'(bus.dcache_resp), 128'(0));
        check("pmem_idle", {126'b0, bus.pmem_read, bus.pmem_write}, 128'(0));
    endtask

    initial begin
        int t;
        bus.dcache_req = 1'b0;
        bus.dcache_addr = '0;
        bus.dcache_wr_en = 1'b0;
        bus.dcache_wr_sel = '0;
        bus.dcache_wdata = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_resp", 128'(bus.dcache_resp), 128'(0));
        check("rst_rdata", bus.dcache_rdata, 128'(0));
        check("rst_pmem_rw", {126'b0, bus.pmem_read, bus.pmem_write}, 128'(0));
        check("rst_pmem_addr", 128'(bus.pmem_addr), 128'(0));
        check("rst_pmem_wdata", bus.pmem_wdata, 128'(0));
        rst_n = 1'b1;

        mem[16'h1230] = 128'h0F0E0D0C0B0A09080706050403020100;
        access(16'h1230, 1'b0, 16'h0000, 128'h0);
        access(16'h1236, 1'b0, 16'h0000, 128'h0);
        access(16'h1230, 1'b1, 16'h0003, 128'hBEEF);
        access(16'h1230, 1'b0, 16'h0000, 128'h0);
        check("merged_line", m_data[3], 128'h0F0E0D0C0B0A0908070605040302BEEF);
        access(16'h2230, 1'b0, 16'h0000, 128'h0);
        check("wb_to_mem", mem[16'h1230], 128'h0F0E0D0C0B0A0908070605040302BEEF);
`ifdef DCACHE_PERF_EN
        check("perf_hits", 128'(perf_hits), 128'(n_hit));
        check("perf_misses", 128'(perf_misses), 128'(n_miss));
`endif

        @(negedge clk);
        bus.dcache_req = 1'b1;
        bus.dcache_addr = 16'h4450;
        bus.dcache_wr_en = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.pmem_read && t < 20);
        check("fill_reached", 128'(bus.pmem_read), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_drops_read", 128'(bus.pmem_read), 128'(0));
        check("rst_drops_addr", 128'(bus.pmem_addr), 128'(0));
        bus.dcache_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        access(16'h4450, 1'b0, 16'h0000, 128'h0);
        access(16'h2230, 1'b0, 16'h0000, 128'h0);

        for (int k = 0; k < 300; k++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 3)) << 7 | 16'($urandom_range(0, 7)) << 4 | 16'($urandom_range(0, 15)) | 16'h5000;
            access(a, 1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
`ifdef DCACHE_PERF_EN
        check("perf_hits_end", 128'(perf_hits), 128'(n_hit));
        check("perf_misses_end", 128'(perf_misses), 128'(n_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
